// File: rtl/dds_ctrl_pkg.sv
package dds_ctrl_pkg;

  localparam int TW_W  = 12;
  localparam int IDX_W = 3;
  localparam int N_TW  = 8;

  // Tuning word per frequency index, 50 MHz clock, 12-bit phase.
  localparam int unsigned TW_TABLE [N_TW] = '{262, 524, 786, 1048, 1311, 1573, 1835, 2097};

  typedef enum logic [1:0] {
    ST_MANUAL,
    ST_SWEEP,
    ST_SETTLE
  } state_e;

endpackage

// File: rtl/key_debounce.sv
module key_debounce #(
  parameter int DEB_CYC = 500000,
  parameter int W       = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] key,
  output logic [W-1:0] key_deb
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic [W-1:0]  key_s1;
  logic [W-1:0]  key_s2;
  logic [W-1:0]  cand;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end

  // The mismatch cycle counts as the first stable sample, so the value is
  // accepted once DEB_CYC consecutive synced samples have agreed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand    <= '0;
      cnt     <= '0;
      key_deb <= '0;
    end else if (key_s2 != cand) begin
      cand <= key_s2;
      cnt  <= '0;
    end else if (cnt != CW'(DEB_CYC - 1)) begin
      cnt <= cnt + CW'(1);
      if (cnt == CW'(DEB_CYC - 2)) begin
        key_deb <= cand;
      end
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int SMP_DIV = 4,
  parameter int DEB_CYC = 500000,
  parameter int DWELL   = 1250000,
  parameter int SETTLE  = 64,
  parameter int TW_W    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  key,
  input  logic              sweep_en,
  output logic [TW_W-1:0]   tw_out,
  output logic [IDX_W-1:0]  tw_idx,
  output logic              sample_stb,
  output logic              phase_clr,
  output logic              settle,
  output logic              sweep_wrap
);

  localparam int SW  = (SMP_DIV > 1) ? $clog2(SMP_DIV) : 1;
  localparam int DWC = (DWELL > 1)   ? $clog2(DWELL)   : 1;
  localparam int STC = (SETTLE > 1)  ? $clog2(SETTLE)  : 1;

  logic [IDX_W-1:0] key_deb;
  logic [SW-1:0]    smp_cnt;

  state_e           state;
  state_e           state_n;
  logic [IDX_W-1:0] idx_n;
  logic [IDX_W-1:0] commit_idx;
  logic             commit;
  logic             pclr_n;
  logic             settle_n;
  logic             wrap_n;
  logic [DWC-1:0]   dwell_cnt;
  logic [DWC-1:0]   dwell_n;
  logic [STC-1:0]   set_cnt;
  logic [STC-1:0]   scnt_n;

  key_debounce #(
    .DEB_CYC (DEB_CYC),
    .W       (IDX_W)
  ) u_key_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .key     (key),
    .key_deb (key_deb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt    <= '0;
      sample_stb <= 1'b0;
    end else begin
      sample_stb <= (smp_cnt == SW'(SMP_DIV - 1));
      if (smp_cnt == SW'(SMP_DIV - 1)) begin
        smp_cnt <= '0;
      end else begin
        smp_cnt <= smp_cnt + SW'(1);
      end
    end
  end

  // Each branch only requests a commit; the common commit effects
  // (index load, phase clear, settle restart) are applied once below.
  always_comb begin
    state_n    = state;
    idx_n      = tw_idx;
    commit     = 1'b0;
    commit_idx = tw_idx;
    pclr_n     = 1'b0;
    settle_n   = settle;
    wrap_n     = 1'b0;
    dwell_n    = dwell_cnt;
    scnt_n     = set_cnt;

    case (state)
      ST_MANUAL: begin
        if (key_deb != tw_idx) begin
          commit     = 1'b1;
          commit_idx = key_deb;
        end else if (sweep_en) begin
          state_n = ST_SWEEP;
          dwell_n = '0;
        end
      end
      ST_SWEEP: begin
        if (!sweep_en) begin
          state_n = ST_MANUAL;
        end else if (sample_stb) begin
          if (dwell_cnt == DWC'(DWELL - 1)) begin
            commit     = 1'b1;
            commit_idx = tw_idx + IDX_W'(1);
            wrap_n     = (tw_idx == '1);
          end else begin
            dwell_n = dwell_cnt + DWC'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (!sweep_en && (key_deb != tw_idx)) begin
          commit     = 1'b1;
          commit_idx = key_deb;
        end else if (sample_stb) begin
          if (set_cnt == STC'(SETTLE - 1)) begin
            settle_n = 1'b0;
            if (sweep_en) begin
              state_n = ST_SWEEP;
              dwell_n = '0;
            end else begin
              state_n = ST_MANUAL;
            end
          end else begin
            scnt_n = set_cnt + STC'(1);
          end
        end
      end
      default: begin
        state_n = ST_MANUAL;
      end
    endcase

    if (commit) begin
      state_n  = ST_SETTLE;
      idx_n    = commit_idx;
      pclr_n   = 1'b1;
      settle_n = 1'b1;
      scnt_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_MANUAL;
      tw_idx     <= '0;
      tw_out     <= TW_W'(TW_TABLE[0]);
      phase_clr  <= 1'b0;
      settle     <= 1'b0;
      sweep_wrap <= 1'b0;
      dwell_cnt  <= '0;
      set_cnt    <= '0;
    end else begin
      state      <= state_n;
      tw_idx     <= idx_n;
      tw_out     <= TW_W'(TW_TABLE[idx_n]);
      phase_clr  <= pclr_n;
      settle     <= settle_n;
      sweep_wrap <= wrap_n;
      dwell_cnt  <= dwell_n;
      set_cnt    <= scnt_n;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
module tb_dds_sweep_ctrl;

  localparam int SMP_DIV = 4;
  localparam int DEB_CYC = 8;
  localparam int DWELL   = 16;
  localparam int SETTLE  = 4;
  localparam int TW_W    = 12;

  localparam int unsigned TWT [8] = '{262, 524, 786, 1048, 1311, 1573, 1835, 2097};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      key = 3'd0;
  logic            sweep_en = 1'b0;
  logic [TW_W-1:0] tw_out;
  logic [2:0]      tw_idx;
  logic            sample_stb;
  logic            phase_clr;
  logic            settle;
  logic            sweep_wrap;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(
    .SMP_DIV (SMP_DIV),
    .DEB_CYC (DEB_CYC),
    .DWELL   (DWELL),
    .SETTLE  (SETTLE),
    .TW_W    (TW_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .sweep_en   (sweep_en),
    .tw_out     (tw_out),
    .tw_idx     (tw_idx),
    .sample_stb (sample_stb),
    .phase_clr  (phase_clr),
    .settle     (settle),
    .sweep_wrap (sweep_wrap)
  );

  // ---------------- behavioural reference model ----------------
  logic [2:0] m_idx = 3'd0;
  logic [2:0] m_deb = 3'd0;
  bit         m_pclr = 1'b0;
  bit         m_settle = 1'b0;
  bit         m_wrap = 1'b0;
  bit         m_stb = 1'b0;
  bit         m_sweeping = 1'b0;
  int         m_sset = 0;
  int         m_dwell = 0;
  int         m_n = 0;
  logic [2:0] samp [10];

  task automatic model_step();
    bit         go;
    bit         stable;
    logic [2:0] nv;
    if (!rst_n) begin
      m_idx = 3'd0; m_deb = 3'd0; m_pclr = 1'b0; m_settle = 1'b0; m_wrap = 1'b0;
      m_stb = 1'b0; m_sweeping = 1'b0; m_sset = 0; m_dwell = 0; m_n = 0;
      for (int j = 0; j < 10; j++) samp[j] = 3'd0;
      return;
    end
    go = 1'b0; nv = m_idx; m_pclr = 1'b0; m_wrap = 1'b0;
    if (m_settle) begin
      if (!sweep_en && m_deb != m_idx) begin
        go = 1'b1; nv = m_deb;
      end else if (m_stb) begin
        m_sset++;
        if (m_sset == SETTLE) begin
          m_settle = 1'b0; m_sweeping = sweep_en; m_dwell = 0;
        end
      end
    end else if (m_sweeping) begin
      if (!sweep_en) begin
        m_sweeping = 1'b0;
      end else if (m_stb) begin
        m_dwell++;
        if (m_dwell == DWELL) begin
          go = 1'b1; nv = m_idx + 3'd1; m_wrap = (m_idx == 3'd7);
        end
      end
    end else begin
      if (m_deb != m_idx) begin
        go = 1'b1; nv = m_deb;
      end else if (sweep_en) begin
        m_sweeping = 1'b1; m_dwell = 0;
      end
    end
    if (go) begin
      m_idx = nv; m_pclr = 1'b1; m_settle = 1'b1; m_sset = 0;
    end
    m_n++;
    m_stb = ((m_n % SMP_DIV) == 0);
    // Raw samples age by one per clock; two sync stages, then DEB_CYC agreeing samples.
    for (int j = 9; j > 0; j--) samp[j] = samp[j-1];
    samp[0] = key;
    stable = 1'b1;
    for (int j = 3; j <= 9; j++) if (samp[j] != samp[2]) stable = 1'b0;
    if (stable) m_deb = samp[2];
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    checks++;
    if (tw_idx !== m_idx || tw_out !== TW_W'(TWT[m_idx]) || sample_stb !== m_stb ||
        phase_clr !== m_pclr || settle !== m_settle || sweep_wrap !== m_wrap) begin
      failures++;
      $display("FAIL model_cmp @%0t: dut idx=%0d tw=%0d stb=%0b pclr=%0b settle=%0b wrap=%0b; model idx=%0d tw=%0d stb=%0b pclr=%0b settle=%0b wrap=%0b",
               $time, tw_idx, tw_out, sample_stb, phase_clr, settle, sweep_wrap,
               m_idx, TWT[m_idx], m_stb, m_pclr, m_settle, m_wrap);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pclr(input int maxc, output int c, output bit settle_held);
    c = 0;
    settle_held = 1'b1;
    do begin
      tick(1);
      c++;
      if (settle !== 1'b1) settle_held = 1'b0;
    end while (phase_clr !== 1'b1 && c < maxc);
    check("pclr_seen", int'(phase_clr), 1);
  endtask

  task automatic settle_run(output int nstb, output int npclr);
    int g;
    g = 0; nstb = 0; npclr = 0;
    while (settle === 1'b1 && g < 300) begin
      if (sample_stb) nstb++;
      if (phase_clr) npclr++;
      tick(1);
      g++;
    end
    check("settle_ends", int'(settle), 0);
  endtask

  task automatic wait_idx(input logic [2:0] target, input int maxc, output int wraps);
    int c;
    c = 0; wraps = 0;
    while (tw_idx !== target && c < maxc) begin
      tick(1);
      c++;
      if (sweep_wrap) wraps++;
    end
    check("wait_idx", int'(tw_idx), int'(target));
  endtask

  typedef struct {
    logic [2:0] key;
    int         hold;
    bit         glitch;
    int         exp_idx;
    int         exp_tw;
    int         exp_pclr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         c;
    int         n;
    int         nstb;
    int         npclr;
    int         wraps;
    bit         held;
    logic [2:0] prev;
    int         hold_left;

    vecs[0] = '{3'd0, 40, 1'b0, 0, 262,  1};
    vecs[1] = '{3'd5, 5,  1'b1, 0, 262,  0};
    vecs[2] = '{3'd7, 40, 1'b0, 7, 2097, 1};
    vecs[3] = '{3'd2, 7,  1'b1, 7, 2097, 0};
    vecs[4] = '{3'd2, 8,  1'b1, 7, 2097, 2};
    vecs[5] = '{3'd1, 40, 1'b0, 1, 524,  1};
    vecs[6] = '{3'd4, 40, 1'b0, 4, 1311, 1};
    vecs[7] = '{3'd6, 40, 1'b0, 6, 1835, 1};
    vecs[8] = '{3'd2, 40, 1'b0, 2, 786,  1};
    vecs[9] = '{3'd5, 40, 1'b0, 5, 1573, 1};

    // Reset state
    tick(3);
    check("rst_tw_out", int'(tw_out), 262);
    check("rst_tw_idx", int'(tw_idx), 0);
    check("rst_stb", int'(sample_stb), 0);
    check("rst_pclr", int'(phase_clr), 0);
    check("rst_settle", int'(settle), 0);
    check("rst_wrap", int'(sweep_wrap), 0);
    rst_n = 1'b1;

    // Strobe cadence after release
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      check("stb_cadence", int'(sample_stb), int'(i % SMP_DIV == 0));
      check("idle_pclr", int'(phase_clr), 0);
      check("idle_settle", int'(settle), 0);
    end

    // Key 0 -> 3
    key = 3'd3;
    wait_pclr(30, c, held);
    check("deb_latency_window", int'(c >= 10 && c <= 12), 1);
    check("k3_idx", int'(tw_idx), 3);
    check("k3_tw", int'(tw_out), 1048);
    settle_run(nstb, npclr);
    check("k3_settle_strobes", nstb, SETTLE);
    check("k3_pclr_count", npclr, 1);

    // Table-driven key changes and glitches
    prev = 3'd3;
    for (int v = 0; v < 10; v++) begin
      n = 0;
      key = vecs[v].key;
      for (int i = 0; i < vecs[v].hold; i++) begin
        tick(1);
        if (phase_clr) n++;
      end
      if (vecs[v].glitch) begin
        key = prev;
        for (int i = 0; i < 40; i++) begin
          tick(1);
          if (phase_clr) n++;
        end
      end else begin
        prev = vecs[v].key;
      end
      check("vec_idx", int'(tw_idx), vecs[v].exp_idx);
      check("vec_tw", int'(tw_out), vecs[v].exp_tw);
      check("vec_pclr", n, vecs[v].exp_pclr);
      check("vec_settle", int'(settle), 0);
    end

    // Sweep from idx 6 through the wrap
    key = 3'd6;
    tick(40);
    check("sw_start_idx", int'(tw_idx), 6);
    sweep_en = 1'b1;
    wait_idx(3'd7, 200, wraps);
    check("sw_to7_tw", int'(tw_out), 2097);
    check("sw_to7_wrap", wraps, 0);
    wait_idx(3'd0, 300, wraps);
    check("sw_to0_tw", int'(tw_out), 262);
    check("sw_to0_wrap", wraps, 1);
    check("sw_to0_pclr", int'(phase_clr), 1);
    sweep_en = 1'b0;
    tick(40);
    check("sw_exit_key_commit", int'(tw_idx), 6);

    // Manual re-commit during settle
    key = 3'd1;
    tick(40);
    key = 3'd2;
    wait_pclr(30, c, held);
    check("rc1_tw", int'(tw_out), 786);
    key = 3'd4;
    wait_pclr(30, c, held);
    check("rc2_settle_held", int'(held), 1);
    check("rc2_idx", int'(tw_idx), 4);
    check("rc2_tw", int'(tw_out), 1311);
    settle_run(nstb, npclr);
    check("rc2_settle_strobes", nstb, SETTLE);
    check("rc2_pclr_count", npclr, 1);

    // Reset during sweep at idx 5
    key = 3'd5;
    tick(40);
    sweep_en = 1'b1;
    tick(10);
    check("mr_pre_idx", int'(tw_idx), 5);
    rst_n = 1'b0;
    #1;
    check("mr_tw", int'(tw_out), 262);
    check("mr_idx", int'(tw_idx), 0);
    check("mr_stb", int'(sample_stb), 0);
    check("mr_pclr", int'(phase_clr), 0);
    check("mr_settle", int'(settle), 0);
    check("mr_wrap", int'(sweep_wrap), 0);
    key = 3'd0;
    sweep_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      check("mr_stb_cadence", int'(sample_stb), int'(i % SMP_DIV == 0));
      check("mr_post_idx", int'(tw_idx), 0);
      check("mr_post_pclr", int'(phase_clr), 0);
    end

    // Randomized stimulus against the model
    hold_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold_left == 0) begin
        key = 3'($urandom_range(0, 7));
        hold_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : int'($urandom_range(10, 60));
      end
      hold_left--;
      if ($urandom_range(0, 149) == 0) sweep_en = ~sweep_en;
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
